// File: rtl/cache_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter_pkg
// Brief    : Shared types and default widths for the I/D-cache line-port
//            arbiter (state encoding, requester identity, line geometry).
// Options  : ARB_ROUND_ROBIN_EN (consumed by arb_select / cache_arbiter)
// Revision : 1.0 - initial release
// ============================================================================
package cache_arbiter_pkg;

   // Default line geometry used by the interface and the top level
   localparam int c_ADDR_W = 32;
   localparam int c_LINE_W = 256;

   // Arbiter FSM states; the top level keeps its own fixed-width copies
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2
   } arb_state_t;

   // Which L1 cache owns the memory port
   typedef enum logic {
      REQ_I = 1'b0,
      REQ_D = 1'b1
   } requester_t;

endpackage : cache_arbiter_pkg
`default_nettype wire

// File: rtl/cache_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter_if
// Brief    : Bundle of the I-cache, D-cache and memory line-port signals seen
//            by the arbiter. The slave modport is the arbiter's view; the
//            master modport is the surrounding caches plus memory.
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
interface cache_arbiter_if
   import cache_arbiter_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int LINE_W = c_LINE_W
) ();

   // I-cache side
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;

   // D-cache side
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;

   // Memory side
   logic              m_read;
   logic              m_write;
   logic [ADDR_W-1:0] m_addr;
   logic [LINE_W-1:0] m_wdata;
   logic [LINE_W-1:0] m_rdata;
   logic              m_resp;

   // Status
   logic              busy;

   // Caches and memory model
   modport master (
      output i_read, i_addr,
      output d_read, d_write, d_addr, d_wdata,
      output m_rdata, m_resp,
      input  i_rdata, i_resp,
      input  d_rdata, d_resp,
      input  m_read, m_write, m_addr, m_wdata,
      input  busy
   );

   // Arbiter
   modport slave (
      input  i_read, i_addr,
      input  d_read, d_write, d_addr, d_wdata,
      input  m_rdata, m_resp,
      output i_rdata, i_resp,
      output d_rdata, d_resp,
      output m_read, m_write, m_addr, m_wdata,
      output busy
   );

endinterface : cache_arbiter_if
`default_nettype wire

// File: rtl/cache_arbiter_arb_select.sv
`default_nettype none
// ============================================================================
// Module   : arb_select
// Brief    : Combinational grant selection between the I-cache and D-cache
//            requests. A lone requester always wins; a conflict is resolved
//            by fixed D priority or, when enabled, round-robin on last_grant.
// Options  : ARB_ROUND_ROBIN_EN - round-robin conflict resolution
// Revision : 1.0 - initial release
// ============================================================================
module arb_select
   import cache_arbiter_pkg::*;
(
   input  wire        i_req,
   input  wire        d_req,
`ifdef ARB_ROUND_ROBIN_EN
   input  requester_t last_grant,
`endif
   output logic       grant_valid,
   output requester_t grant_id
);

   // Pick the owner of the next memory transaction
   always_comb begin
      grant_valid = i_req | d_req;
      grant_id    = REQ_I;
      if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
         // Whoever did not win last time gets this one
         grant_id = (last_grant == REQ_I) ? REQ_D : REQ_I;
`else
         // Data misses stall the pipeline harder, so D wins every conflict
         grant_id = REQ_D;
`endif
      end else if (d_req) begin
         grant_id = REQ_D;
      end
   end

endmodule : arb_select
`default_nettype wire

// File: rtl/cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_arbiter
// Brief    : Shares one physical-memory line port between the I-cache and the
//            D-cache. One line transaction in flight; m_* are registered at
//            grant and held until m_resp, which is passed straight back to the
//            owning cache in the same cycle.
// Options  : ARB_ROUND_ROBIN_EN - round-robin conflict resolution (adds the
//            last_grant register); undefined gives fixed D-cache priority.
// Revision : 1.0 - initial release
// ============================================================================
module cache_arbiter
   import cache_arbiter_pkg::*;
#(
   parameter int ADDR_W = c_ADDR_W,
   parameter int LINE_W = c_LINE_W
) (
   input  wire            clk,
   input  wire            rst_n,
   cache_arbiter_if.slave bus
);

   // Fixed-width state encodings mirroring arb_state_t
   localparam logic [1:0] c_ST_IDLE    = IDLE;
   localparam logic [1:0] c_ST_SERVE_I = SERVE_I;
   localparam logic [1:0] c_ST_SERVE_D = SERVE_D;

   logic [1:0]        r_state;
   logic              r_m_read;
   logic              r_m_write;
   logic [ADDR_W-1:0] r_m_addr;
   logic [LINE_W-1:0] r_m_wdata;

   logic              w_i_req;
   logic              w_d_req;
   logic              w_grant_valid;
   requester_t        w_grant_id;
   logic              w_idle;
   logic              w_i_resp;
   logic              w_d_resp;

   assign w_i_req = bus.i_read;
   assign w_d_req = bus.d_read | bus.d_write;
   assign w_idle  = (r_state == c_ST_IDLE);

`ifdef ARB_ROUND_ROBIN_EN
   requester_t r_last_grant;

   // Remember the most recent winner so the other side wins the next conflict
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_last_grant <= REQ_I;
      end else if (w_idle && w_grant_valid) begin
         r_last_grant <= w_grant_id;
      end
   end
`endif

   arb_select u_arb_select (
      .i_req       (w_i_req),
      .d_req       (w_d_req),
`ifdef ARB_ROUND_ROBIN_EN
      .last_grant  (r_last_grant),
`endif
      .grant_valid (w_grant_valid),
      .grant_id    (w_grant_id)
   );

   // FSM and memory-port registers: latch the winner's request at grant,
   // hold it for the whole transaction, drop the strobe when memory answers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= c_ST_IDLE;
         r_m_read  <= 1'b0;
         r_m_write <= 1'b0;
         r_m_addr  <= '0;
         r_m_wdata <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_grant_valid) begin
                  if (w_grant_id == REQ_D) begin
                     r_state   <= c_ST_SERVE_D;
                     r_m_addr  <= bus.d_addr;
                     r_m_wdata <= bus.d_wdata;
                     // A simultaneous read and write is illegal; read wins
                     r_m_read  <= bus.d_read;
                     r_m_write <= ~bus.d_read & bus.d_write;
                  end else begin
                     r_state   <= c_ST_SERVE_I;
                     r_m_addr  <= bus.i_addr;
                     r_m_wdata <= '0;
                     r_m_read  <= 1'b1;
                     r_m_write <= 1'b0;
                  end
               end
            end
            c_ST_SERVE_I, c_ST_SERVE_D: begin
               if (bus.m_resp) begin
                  r_state   <= c_ST_IDLE;
                  r_m_read  <= 1'b0;
                  r_m_write <= 1'b0;
               end
            end
            default: begin
               r_state   <= c_ST_IDLE;
               r_m_read  <= 1'b0;
               r_m_write <= 1'b0;
            end
         endcase
      end
   end

   // Completion is steered to the owner in the same cycle as m_resp; a stray
   // m_resp in IDLE or during reset reaches nobody
   assign w_i_resp = rst_n & (r_state == c_ST_SERVE_I) & bus.m_resp;
   assign w_d_resp = rst_n & (r_state == c_ST_SERVE_D) & bus.m_resp;

   assign bus.i_resp  = w_i_resp;
   assign bus.d_resp  = w_d_resp;
   assign bus.i_rdata = w_i_resp ? bus.m_rdata : '0;
   assign bus.d_rdata = w_d_resp ? bus.m_rdata : '0;

   assign bus.m_read  = r_m_read;
   assign bus.m_write = r_m_write;
   assign bus.m_addr  = r_m_addr;
   assign bus.m_wdata = r_m_wdata;
   assign bus.busy    = ~w_idle;

endmodule : cache_arbiter
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_arbiter
// Brief    : Directed and randomised self-checking bench for cache_arbiter.
//            Expectations follow the arbitration mode selected by
//            ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_arbiter;
   import cache_arbiter_pkg::*;

   localparam int AW = 32;
   localparam int LW = 256;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cache_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

   cache_arbiter #(.ADDR_W(AW), .LINE_W(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

`ifdef ARB_ROUND_ROBIN_EN
   requester_t exp_last;
`endif

   // The D-cache must never present read and write together
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(bus.d_read && bus.d_write))
            else $error("FAIL d_rw_illegal: d_read and d_write both high");
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.i_read  = 1'b0;
      bus.i_addr  = '0;
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
      bus.d_addr  = '0;
      bus.d_wdata = '0;
      bus.m_rdata = '0;
      bus.m_resp  = 1'b0;
   endtask

   task automatic apply_reset();
      drive_idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      exp_last = REQ_I;
`endif
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({bus.m_read, bus.m_write, bus.busy, bus.i_resp, bus.d_resp} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b want 00000",
                  {bus.m_read, bus.m_write, bus.busy, bus.i_resp, bus.d_resp});
      end
      n_cmp++;
      if ({bus.m_addr, bus.m_wdata} !== '0) begin
         n_err++;
         $display("FAIL reset_data: addr %h wdata %h want 0", bus.m_addr, bus.m_wdata);
      end

      // Get into SERVE_D with m_read high, then reset for 2 cycles
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_4000;
      tick();
      n_cmp++;
      if ({bus.m_read, bus.busy} !== 2'b11) begin
         n_err++;
         $display("FAIL reset_pre_grant: m_read,busy got %b want 11", {bus.m_read, bus.busy});
      end
      rst_n = 1'b0;
      tick();
      tick();
      n_cmp++;
      if ({bus.m_read, bus.m_write, bus.busy} !== 3'b000 || bus.m_addr !== '0) begin
         n_err++;
         $display("FAIL reset_mid_serve: m_read,m_write,busy %b addr %h want 000 0",
                  {bus.m_read, bus.m_write, bus.busy}, bus.m_addr);
      end
      bus.d_read = 1'b0;
      rst_n      = 1'b1;
      tick();

      // Stray memory response in IDLE must be ignored
      bus.m_rdata = '1;
      bus.m_resp  = 1'b1;
      #1;
      n_cmp++;
      if ({bus.i_resp, bus.d_resp} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_stray_resp: i_resp,d_resp got %b want 00", {bus.i_resp, bus.d_resp});
      end
      tick();
      bus.m_resp = 1'b0;
      n_cmp++;
      if ({bus.m_read, bus.m_write, bus.busy} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_stray_state: got %b want 000", {bus.m_read, bus.m_write, bus.busy});
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_lone_i();
      logic [LW-1:0] a5;
      a5 = {32{8'hA5}};
      bus.i_read = 1'b1;
      bus.i_addr = 32'h0000_1000;
      tick();
      n_cmp++;
      if ({bus.m_read, bus.m_write, bus.busy, bus.i_resp, bus.d_resp} !== 5'b10100
          || bus.m_addr !== 32'h0000_1000) begin
         n_err++;
         $display("FAIL lone_i_grant: rd,wr,busy,ir,dr %b addr %h want 10100 00001000",
                  {bus.m_read, bus.m_write, bus.busy, bus.i_resp, bus.d_resp}, bus.m_addr);
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if ({bus.m_read, bus.m_write, bus.i_resp, bus.d_resp} !== 4'b1000
             || bus.m_addr !== 32'h0000_1000) begin
            n_err++;
            $display("FAIL lone_i_hold: cycle %0d rd,wr,ir,dr %b addr %h", k,
                     {bus.m_read, bus.m_write, bus.i_resp, bus.d_resp}, bus.m_addr);
         end
      end
      bus.m_rdata = a5;
      bus.m_resp  = 1'b1;
      #1;
      n_cmp++;
      if ({bus.i_resp, bus.d_resp} !== 2'b10) begin
         n_err++;
         $display("FAIL lone_i_resp: i_resp,d_resp got %b want 10", {bus.i_resp, bus.d_resp});
      end
      n_cmp++;
      if (bus.i_rdata !== a5 || bus.d_rdata !== '0) begin
         n_err++;
         $display("FAIL lone_i_rdata: i_rdata %h d_rdata %h want %h and 0", bus.i_rdata, bus.d_rdata, a5);
      end
      tick();
      bus.m_resp = 1'b0;
      bus.i_read = 1'b0;
      #1;
      n_cmp++;
      if ({bus.m_read, bus.busy, bus.i_resp, bus.d_resp} !== 4'b0000) begin
         n_err++;
         $display("FAIL lone_i_done: rd,busy,ir,dr got %b want 0000",
                  {bus.m_read, bus.busy, bus.i_resp, bus.d_resp});
      end
      tick();
      n_cmp++;
      if ({bus.m_read, bus.busy, bus.i_resp} !== 3'b000) begin
         n_err++;
         $display("FAIL lone_i_no_regrant: rd,busy,ir got %b want 000", {bus.m_read, bus.busy, bus.i_resp});
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_d_writeback();
      logic [LW-1:0] wd;
      wd = {8{32'h1234_5678}};
      bus.d_write = 1'b1;
      bus.d_addr  = 32'h0000_2040;
      bus.d_wdata = wd;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if ({bus.m_read, bus.m_write, bus.d_resp, bus.i_resp} !== 4'b0100
             || bus.m_addr !== 32'h0000_2040 || bus.m_wdata !== wd) begin
            n_err++;
            $display("FAIL d_wb_hold: cycle %0d rd,wr,dr,ir %b addr %h wdata %h", k,
                     {bus.m_read, bus.m_write, bus.d_resp, bus.i_resp}, bus.m_addr, bus.m_wdata);
         end
      end
      bus.m_rdata = {8{32'h0BAD_F00D}};
      bus.m_resp  = 1'b1;
      #1;
      n_cmp++;
      if ({bus.i_resp, bus.d_resp} !== 2'b01) begin
         n_err++;
         $display("FAIL d_wb_resp: i_resp,d_resp got %b want 01", {bus.i_resp, bus.d_resp});
      end
      tick();
      bus.m_resp  = 1'b0;
      bus.d_write = 1'b0;
      #1;
      n_cmp++;
      if ({bus.m_write, bus.m_read, bus.busy, bus.d_resp} !== 4'b0000) begin
         n_err++;
         $display("FAIL d_wb_done: wr,rd,busy,dr got %b want 0000",
                  {bus.m_write, bus.m_read, bus.busy, bus.d_resp});
      end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_d_read_fast();
      logic [LW-1:0] rd;
      rd = {8{32'hDEAD_BEEF}};
      bus.d_read = 1'b1;
      bus.d_addr = 32'h0000_2080;
      tick();
      // Memory answers in the very first serve cycle
      bus.m_rdata = rd;
      bus.m_resp  = 1'b1;
      #1;
      n_cmp++;
      if ({bus.m_read, bus.m_write, bus.d_resp, bus.i_resp} !== 4'b1010
          || bus.m_addr !== 32'h0000_2080) begin
         n_err++;
         $display("FAIL d_read_fast: rd,wr,dr,ir %b addr %h want 1010 00002080",
                  {bus.m_read, bus.m_write, bus.d_resp, bus.i_resp}, bus.m_addr);
      end
      n_cmp++;
      if (bus.d_rdata !== rd || bus.i_rdata !== '0) begin
         n_err++;
         $display("FAIL d_read_fast_rdata: d_rdata %h i_rdata %h want %h and 0", bus.d_rdata, bus.i_rdata, rd);
      end
      tick();
      bus.m_resp = 1'b0;
      bus.d_read = 1'b0;
      tick();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_conflict();
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      logic [AW-1:0] ea;
      requester_t    win;
      apply_reset();
      ia = 32'h1000_0000;
      da = 32'h2000_0000;
      bus.i_read = 1'b1;
      bus.i_addr = ia;
      bus.d_read = 1'b1;
      bus.d_addr = da;
      for (int r = 0; r < 3; r++) begin
`ifdef ARB_ROUND_ROBIN_EN
         win = (exp_last == REQ_I) ? REQ_D : REQ_I;
         exp_last = win;
`else
         win = REQ_D;
`endif
         ea = (win == REQ_D) ? da : ia;
         tick();
         n_cmp++;
         if ({bus.m_read, bus.m_write} !== 2'b10 || bus.m_addr !== ea) begin
            n_err++;
            $display("FAIL conflict_grant: round %0d rd,wr %b addr %h want 10 %h", r,
                     {bus.m_read, bus.m_write}, bus.m_addr, ea);
         end
         tick();
         bus.m_rdata = {8{ea}};
         bus.m_resp  = 1'b1;
         #1;
         n_cmp++;
         if ({bus.i_resp, bus.d_resp} !== ((win == REQ_D) ? 2'b01 : 2'b10)
             || ((win == REQ_D) ? bus.d_rdata : bus.i_rdata) !== {8{ea}}) begin
            n_err++;
            $display("FAIL conflict_resp: round %0d ir,dr %b winner D=%0d", r,
                     {bus.i_resp, bus.d_resp}, (win == REQ_D));
         end
         tick();
         bus.m_resp = 1'b0;
         // The winner immediately presents its next miss
         if (win == REQ_D) begin
            da = da + 32'h40;
            bus.d_addr = da;
         end else begin
            ia = ia + 32'h40;
            bus.i_addr = ia;
         end
         #1;
         n_cmp++;
         if ({bus.m_read, bus.m_write, bus.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL conflict_gap: round %0d rd,wr,busy got %b want 000", r,
                     {bus.m_read, bus.m_write, bus.busy});
         end
      end
      // With the D-cache quiet, the I-cache is served
      bus.d_read = 1'b0;
      tick();
      n_cmp++;
      if ({bus.m_read, bus.m_write} !== 2'b10 || bus.m_addr !== ia) begin
         n_err++;
         $display("FAIL conflict_i_last: rd,wr %b addr %h want 10 %h", {bus.m_read, bus.m_write}, bus.m_addr, ia);
      end
      bus.m_resp = 1'b1;
      #1;
      n_cmp++;
      if ({bus.i_resp, bus.d_resp} !== 2'b10) begin
         n_err++;
         $display("FAIL conflict_i_last_resp: ir,dr got %b want 10", {bus.i_resp, bus.d_resp});
      end
      tick();
      bus.m_resp = 1'b0;
      bus.i_read = 1'b0;
      tick();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_back_to_back();
      logic          i_pend;
      logic          d_pend;
      logic          dw;
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      logic [LW-1:0] dwd;
      logic [LW-1:0] rd;
      logic          e_rd;
      logic          e_wr;
      logic [AW-1:0] e_addr;
      logic [LW-1:0] e_wd;
      requester_t    win;
      int            lat;
      apply_reset();
      i_pend = 1'b0;
      d_pend = 1'b0;
      dw     = 1'b0;
      ia     = '0;
      da     = '0;
      dwd    = '0;
      for (int t = 0; t < 1000; t++) begin
         if (!i_pend && ($urandom_range(0, 2) != 0)) begin
            i_pend     = 1'b1;
            ia         = $urandom & 32'hFFFF_FFE0;
            bus.i_addr = ia;
            bus.i_read = 1'b1;
         end
         if (!d_pend && ($urandom_range(0, 2) != 0)) begin
            d_pend = 1'b1;
            dw     = ($urandom_range(0, 1) == 1);
            da     = $urandom & 32'hFFFF_FFE0;
            for (int w = 0; w < 8; w++) dwd[w*32 +: 32] = $urandom;
            bus.d_addr  = da;
            bus.d_wdata = dwd;
            bus.d_read  = ~dw;
            bus.d_write = dw;
         end
         if (!i_pend && !d_pend) begin
            i_pend     = 1'b1;
            ia         = $urandom & 32'hFFFF_FFE0;
            bus.i_addr = ia;
            bus.i_read = 1'b1;
         end

         if (i_pend && d_pend) begin
`ifdef ARB_ROUND_ROBIN_EN
            win = (exp_last == REQ_I) ? REQ_D : REQ_I;
`else
            win = REQ_D;
`endif
         end else begin
            win = d_pend ? REQ_D : REQ_I;
         end
`ifdef ARB_ROUND_ROBIN_EN
         exp_last = win;
`endif
         e_rd   = (win == REQ_I) ? 1'b1 : ~dw;
         e_wr   = (win == REQ_D) & dw;
         e_addr = (win == REQ_D) ? da : ia;
         e_wd   = (win == REQ_D) ? dwd : '0;

         tick();
         n_cmp++;
         if ({bus.m_read, bus.m_write, bus.m_addr, bus.m_wdata} !== {e_rd, e_wr, e_addr, e_wd}) begin
            n_err++;
            $display("FAIL b2b_grant: txn %0d rd,wr %b addr %h want %b %h (D=%0d)", t,
                     {bus.m_read, bus.m_write}, bus.m_addr, {e_rd, e_wr}, e_addr, (win == REQ_D));
         end

         lat = $urandom_range(1, 20);
         for (int c = 1; c < lat; c++) begin
            tick();
            n_cmp++;
            if ({bus.m_read, bus.m_write, bus.m_addr, bus.m_wdata, bus.i_resp, bus.d_resp, bus.busy}
                !== {e_rd, e_wr, e_addr, e_wd, 1'b0, 1'b0, 1'b1}) begin
               n_err++;
               $display("FAIL b2b_hold: txn %0d cycle %0d rd,wr %b addr %h ir,dr,busy %b", t, c,
                        {bus.m_read, bus.m_write}, bus.m_addr, {bus.i_resp, bus.d_resp, bus.busy});
            end
         end

         for (int w = 0; w < 8; w++) rd[w*32 +: 32] = $urandom;
         bus.m_rdata = rd;
         bus.m_resp  = 1'b1;
         #1;
         n_cmp++;
         if ({bus.i_resp, bus.d_resp} !== ((win == REQ_D) ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL b2b_resp: txn %0d ir,dr got %b winner D=%0d", t, {bus.i_resp, bus.d_resp}, (win == REQ_D));
         end
         n_cmp++;
         if (((win == REQ_D) ? bus.d_rdata : bus.i_rdata) !== rd
             || ((win == REQ_D) ? bus.i_rdata : bus.d_rdata) !== '0) begin
            n_err++;
            $display("FAIL b2b_rdata: txn %0d i_rdata %h d_rdata %h", t, bus.i_rdata, bus.d_rdata);
         end

         tick();
         bus.m_resp = 1'b0;
         if (win == REQ_D) begin
            d_pend      = 1'b0;
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
         end else begin
            i_pend     = 1'b0;
            bus.i_read = 1'b0;
         end
         #1;
         n_cmp++;
         if ({bus.m_read, bus.m_write, bus.busy, bus.i_resp, bus.d_resp} !== 5'b00000) begin
            n_err++;
            $display("FAIL b2b_gap: txn %0d rd,wr,busy,ir,dr got %b want 00000", t,
                     {bus.m_read, bus.m_write, bus.busy, bus.i_resp, bus.d_resp});
         end
      end
      drive_idle();
      tick();
   endtask

   // ------------------------------------------------------------------------
   initial begin
      drive_idle();
      test_reset();
      test_lone_i();
      test_d_writeback();
      test_d_read_fast();
      test_conflict();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_cache_arbiter
`default_nettype wire
